spi_reg_controller: RTL and testbench

SPI controller (initiator) that issues two-byte register-access frames toward the design's SPI register-bank target. It generates spi_cs_n, spi_clk and spi_mosi, and samples spi_miso. All four SPI modes are supported. It serves as the on-chip or FPGA-side bench master and the loopback partner for the target. One frame is one register read or write, started by a req/busy/done handshake.

---
 rtl/spi_reg_controller_if.sv | 25 ++
 rtl/spi_reg_controller.sv | 129 ++++++++++++
 tb/tb_spi_reg_controller.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_controller_if.sv
// spi_reg_controller_if: host-side register-access handshake bundle for spi_reg_controller.
// Signals:
//   mode  [1:0]      {CPOL, CPHA} requested for the frame
//   req              start a frame (taken only while busy=0)
//   rnw              1 = read, 0 = write
//   addr  [ADDR_W-1:0] register address
//   wdata [7:0]      write data
//   busy             frame or post-frame gap in progress
//   done             one-cycle end-of-frame pulse
//   rdata [7:0]      byte received during the second frame byte
// Modports: master = host issuing requests, slave = the controller.
interface spi_reg_controller_if #(
   parameter int ADDR_W = 3
);
   logic [1:0]        mode;
   logic              req;
   logic              rnw;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        wdata;
   logic              busy;
   logic              done;
   logic [7:0]        rdata;
   modport master (output mode, req, rnw, addr, wdata, input busy, done, rdata);
   modport slave  (input mode, req, rnw, addr, wdata, output busy, done, rdata);
endinterface

// File: rtl/spi_reg_controller.sv
// spi_reg_controller: SPI initiator issuing two-byte register read/write frames, all four SPI modes.
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   ena        clock enable; low freezes all state and outputs
//   bus        spi_reg_controller_if.slave: mode/req/rnw/addr/wdata in, busy/done/rdata out
//   spi_cs_n   chip select, active low
//   spi_clk    SCLK
//   spi_mosi   serial out, MSB first
//   spi_miso   serial in, MSB first
// Parameters: CLK_DIV = SCLK half-period in clk cycles (2..255), ADDR_W = address width (1..7).
// Build option: define SPI_CTRL_MISO_SYNC_EN to pass spi_miso through a 2-flop synchronizer.
module spi_reg_controller #(
   parameter int CLK_DIV = 8,
   parameter int ADDR_W  = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ena,
   spi_reg_controller_if.slave  bus,
   output logic                 spi_cs_n,
   output logic                 spi_clk,
   output logic                 spi_mosi,
   input  logic                 spi_miso
);
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] LEAD  = 3'd1;
   localparam logic [2:0] SHIFT = 3'd2;
   localparam logic [2:0] LAG   = 3'd3;
   localparam logic [2:0] GAP   = 3'd4;

   logic [2:0]  state;
   logic [7:0]  cnt;
   logic [4:0]  bit_cnt;
   logic        cpol;
   logic        cpha;
   logic [15:0] tx;
   logic [7:0]  rx;
   logic        busy;
   logic        done;
   logic [7:0]  rdata;
   logic        miso_s;
   logic        cnt_end;
   logic        sample;
   logic [15:0] frame;

   assign cnt_end = cnt == 8'(CLK_DIV - 1);
   // bit_cnt counts completed SCLK toggles, so an even count means the next toggle is a leading edge
   assign sample  = bit_cnt[0] == cpha;
   assign frame   = {~bus.rnw, 7'(bus.addr), bus.rnw ? 8'h00 : bus.wdata};

   assign bus.busy  = busy;
   assign bus.done  = done;
   assign bus.rdata = rdata;

`ifdef SPI_CTRL_MISO_SYNC_EN
   logic [1:0] miso_sync;
   always_ff @(posedge clk) begin
      if (!rst_n) miso_sync <= '0;
      else if (ena) miso_sync <= {miso_sync[0], spi_miso};
   end
   assign miso_s = miso_sync[1];
`else
   assign miso_s = spi_miso;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         bit_cnt  <= '0;
         cpol     <= 1'b0;
         cpha     <= 1'b0;
         tx       <= '0;
         rx       <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         rdata    <= '0;
         spi_cs_n <= 1'b1;
         spi_clk  <= 1'b0;
         spi_mosi <= 1'b0;
      end else if (ena) begin
         done <= 1'b0;
         cnt  <= (state == IDLE || cnt_end) ? '0 : cnt + 8'd1;
         case (state)
            IDLE: begin
               spi_clk <= bus.mode[1];
               if (bus.req) begin
                  state         <= LEAD;
                  busy          <= 1'b1;
                  spi_cs_n      <= 1'b0;
                  bit_cnt       <= '0;
                  {cpol, cpha}  <= bus.mode;
                  // CPHA=0 presents bit15 before the first edge; CPHA=1 shifts it out on the first edge
                  tx            <= bus.mode[0] ? frame : {frame[14:0], 1'b0};
                  spi_mosi      <= bus.mode[0] ? 1'b0 : frame[15];
               end
            end
            LEAD: if (cnt_end) state <= SHIFT;
            SHIFT: begin
               if (cnt_end) begin
                  spi_clk <= ~spi_clk;
                  bit_cnt <= bit_cnt + 5'd1;
                  if (sample) rx <= {rx[6:0], miso_s};
                  else begin
                     spi_mosi <= tx[15];
                     tx       <= {tx[14:0], 1'b0};
                  end
                  if (bit_cnt == 5'd31) state <= LAG;
               end
            end
            LAG: begin
               spi_clk <= cpol;
               if (cnt_end) begin
                  state    <= GAP;
                  spi_cs_n <= 1'b1;
                  done     <= 1'b1;
                  rdata    <= rx;
               end
            end
            GAP: if (cnt_end) begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_reg_controller.sv
// tb_spi_reg_controller: randomized self-checking bench for spi_reg_controller with a behavioural SPI target.
module tb_spi_reg_controller;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ena = 1'b1;
   logic spi_cs_n, spi_clk, spi_mosi;
   logic spi_miso = 1'b0;
   int cyc = 0;
   int errs = 0;
   int checks = 0;

   spi_reg_controller_if #(.ADDR_W(3)) bus();

   spi_reg_controller #(.CLK_DIV(8), .ADDR_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus),
      .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural target: counts SCLK toggles while selected, captures mosi on sample edges,
   // presents resp_word MSB-first on shift edges, optionally lat clk cycles late.
   logic [1:0]  t_mode = 2'd0;
   logic [15:0] resp_word = '0;
   logic [15:0] mosi_cap = '0;
   int lat = 0, pend = 0, edges = 0, tx_idx = 0, viol = 0;
   logic pend_bit = 1'b0, cs_prev = 1'b1, sclk_prev = 1'b0, mosi_prev = 1'b0;

   always @(negedge clk) begin
      if (pend > 0) begin
         pend = pend - 1;
         if (pend == 0) spi_miso = pend_bit;
      end
      if (cs_prev && !spi_cs_n) begin
         edges = 0; viol = 0; mosi_cap = '0; pend = 0;
         tx_idx = t_mode[0] ? 0 : 1;
         spi_miso = t_mode[0] ? 1'b0 : resp_word[15];
      end else if (!spi_cs_n) begin
         if (spi_clk != sclk_prev) begin
            edges++;
            if ((edges % 2 == 1) != t_mode[0]) begin
               mosi_cap = {mosi_cap[14:0], spi_mosi};
               if (spi_mosi != mosi_prev) viol++;
            end else if (tx_idx < 16) begin
               if (lat == 0) spi_miso = resp_word[15 - tx_idx];
               else begin
                  pend = lat;
                  pend_bit = resp_word[15 - tx_idx];
               end
               tx_idx++;
            end
         end else if (spi_mosi != mosi_prev) viol++;
      end
      cs_prev = spi_cs_n; sclk_prev = spi_clk; mosi_prev = spi_mosi;
   end

   function automatic logic [15:0] exp_frame(input logic r, input logic [2:0] a, input logic [7:0] w);
      return 16'((r ? 0 : 32768) + int'(a) * 256 + (r ? 0 : int'(w)));
   endfunction

   // Runs one frame; returns done/busy-fall times relative to the accept edge, disabled cycles and extra done cycles.
   task automatic do_frame(input logic [1:0] m, input logic r, input logic [2:0] a, input logic [7:0] w,
                           input logic [7:0] rb, input int l, input bit poke, input bit gate,
                           output int td, output int tbz, output int dis, output int xd);
      int e0;
      td = -1; tbz = -1; dis = 0; xd = 0;
      @(negedge clk);
      bus.mode = m; bus.rnw = r; bus.addr = a; bus.wdata = w; bus.req = 1'b1;
      t_mode = m; resp_word = {8'($urandom), rb}; lat = l;
      @(posedge clk); #1;
      bus.req = 1'b0;
      e0 = cyc;
      for (int i = 0; i < 800 && td < 0; i++) begin
         @(negedge clk);
         if (gate) begin
            ena = ($urandom_range(0, 3) != 0);
            if (!ena) dis++;
         end
         if (poke && cyc - e0 == 49) begin
            bus.req = 1'b1; bus.mode = ~m; bus.rnw = ~r; bus.addr = ~a; bus.wdata = ~w;
         end else bus.req = 1'b0;
         @(posedge clk); #1;
         if (bus.done) td = cyc - e0;
      end
      ena = 1'b1;
      bus.req = poke;
      for (int i = 0; i < 100 && tbz < 0; i++) begin
         @(posedge clk); #1;
         bus.req = 1'b0;
         if (bus.done) xd++;
         if (!bus.busy) tbz = cyc - e0;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (spi_cs_n !== 1'b1) begin errs++; $display("FAIL reset_cs_n got=%b want=1", spi_cs_n); end
      checks++; if (spi_clk !== 1'b0) begin errs++; $display("FAIL reset_sclk got=%b want=0", spi_clk); end
      checks++; if (spi_mosi !== 1'b0) begin errs++; $display("FAIL reset_mosi got=%b want=0", spi_mosi); end
      checks++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errs++; $display("FAIL reset_done got=%b want=0", bus.done); end
      checks++; if (bus.rdata !== 8'h00) begin errs++; $display("FAIL reset_rdata got=%h want=00", bus.rdata); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_mode0_write;
      int td, tbz, dis, xd;
      do_frame(2'd0, 1'b0, 3'd3, 8'hA5, 8'h3C, 0, 1'b0, 1'b0, td, tbz, dis, xd);
      checks++; if (mosi_cap !== 16'h83A5) begin errs++; $display("FAIL m0w_mosi got=%h want=83a5", mosi_cap); end
      checks++; if (edges !== 32) begin errs++; $display("FAIL m0w_edges got=%0d want=32", edges); end
      checks++; if (viol !== 0) begin errs++; $display("FAIL m0w_mosi_timing got=%0d want=0", viol); end
      checks++; if (td !== 272) begin errs++; $display("FAIL m0w_done_time got=%0d want=272", td); end
      checks++; if (tbz !== 280) begin errs++; $display("FAIL m0w_busy_fall got=%0d want=280", tbz); end
      checks++; if (xd !== 0) begin errs++; $display("FAIL m0w_done_width got=%0d want=0", xd); end
      checks++; if (bus.rdata !== 8'h3C) begin errs++; $display("FAIL m0w_rdata got=%h want=3c", bus.rdata); end
      checks++; if (spi_cs_n !== 1'b1) begin errs++; $display("FAIL m0w_cs_after got=%b want=1", spi_cs_n); end
   endtask

   task automatic test_mode0_read;
      int td, tbz, dis, xd;
      do_frame(2'd0, 1'b1, 3'd0, 8'hFF, 8'hCA, 0, 1'b0, 1'b0, td, tbz, dis, xd);
      checks++; if (mosi_cap !== 16'h0000) begin errs++; $display("FAIL m0r_mosi got=%h want=0000", mosi_cap); end
      checks++; if (bus.rdata !== 8'hCA) begin errs++; $display("FAIL m0r_rdata got=%h want=ca", bus.rdata); end
      repeat (20) begin
         @(negedge clk);
         spi_miso = 1'($urandom);
      end
      #1;
      checks++; if (bus.rdata !== 8'hCA) begin errs++; $display("FAIL m0r_rdata_hold got=%h want=ca", bus.rdata); end
   endtask

   task automatic test_modes_write;
      int td, tbz, dis, xd;
      logic [1:0] ms [3] = '{2'd3, 2'd1, 2'd2};
      logic [7:0] rb;
      foreach (ms[k]) begin
         @(negedge clk);
         bus.mode = ms[k];
         repeat (2) @(posedge clk);
         #1;
         checks++; if (spi_clk !== ms[k][1]) begin errs++; $display("FAIL idle_sclk mode=%0d got=%b want=%b", ms[k], spi_clk, ms[k][1]); end
         rb = 8'($urandom);
         do_frame(ms[k], 1'b0, 3'd7, 8'h5A, rb, 0, 1'b0, 1'b0, td, tbz, dis, xd);
         checks++; if (mosi_cap !== 16'h875A) begin errs++; $display("FAIL mw_mosi mode=%0d got=%h want=875a", ms[k], mosi_cap); end
         checks++; if (viol !== 0) begin errs++; $display("FAIL mw_mosi_timing mode=%0d got=%0d want=0", ms[k], viol); end
         checks++; if (edges !== 32) begin errs++; $display("FAIL mw_edges mode=%0d got=%0d want=32", ms[k], edges); end
         checks++; if (bus.rdata !== rb) begin errs++; $display("FAIL mw_rdata mode=%0d got=%h want=%h", ms[k], bus.rdata, rb); end
         checks++; if (td !== 272) begin errs++; $display("FAIL mw_done_time mode=%0d got=%0d want=272", ms[k], td); end
         checks++; if (spi_clk !== ms[k][1]) begin errs++; $display("FAIL mw_sclk_rest mode=%0d got=%b want=%b", ms[k], spi_clk, ms[k][1]); end
      end
   endtask

   task automatic test_ignore_req;
      int td, tbz, dis, xd, bad;
      do_frame(2'd0, 1'b0, 3'd5, 8'h3C, 8'h81, 0, 1'b1, 1'b0, td, tbz, dis, xd);
      checks++; if (mosi_cap !== exp_frame(1'b0, 3'd5, 8'h3C)) begin errs++; $display("FAIL ign_mosi got=%h want=%h", mosi_cap, exp_frame(1'b0, 3'd5, 8'h3C)); end
      checks++; if (td !== 272) begin errs++; $display("FAIL ign_done_time got=%0d want=272", td); end
      checks++; if (tbz !== 280) begin errs++; $display("FAIL ign_busy_fall got=%0d want=280", tbz); end
      bad = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (bus.busy || !spi_cs_n) bad++;
      end
      checks++; if (bad !== 0) begin errs++; $display("FAIL ign_not_queued got=%0d want=0", bad); end
      do_frame(2'd0, 1'b0, 3'd1, 8'h42, 8'h5C, 0, 1'b0, 1'b0, td, tbz, dis, xd);
      checks++; if (mosi_cap !== 16'h8142) begin errs++; $display("FAIL ign_next_mosi got=%h want=8142", mosi_cap); end
      checks++; if (bus.rdata !== 8'h5C) begin errs++; $display("FAIL ign_next_rdata got=%h want=5c", bus.rdata); end
   endtask

   task automatic test_reset_mid;
      int e0, td, tbz, dis, xd, nd;
      @(negedge clk);
      bus.mode = 2'd0; bus.rnw = 1'b0; bus.addr = 3'd6; bus.wdata = 8'h77; bus.req = 1'b1;
      t_mode = 2'd0; resp_word = 16'h1234; lat = 0;
      @(posedge clk); #1;
      bus.req = 1'b0;
      e0 = cyc;
      while (cyc - e0 < 99) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      checks++; if (spi_cs_n !== 1'b1) begin errs++; $display("FAIL rmid_cs_n got=%b want=1", spi_cs_n); end
      checks++; if (spi_clk !== 1'b0) begin errs++; $display("FAIL rmid_sclk got=%b want=0", spi_clk); end
      checks++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL rmid_busy got=%b want=0", bus.busy); end
      checks++; if (bus.rdata !== 8'h00) begin errs++; $display("FAIL rmid_rdata got=%h want=00", bus.rdata); end
      rst_n = 1'b1;
      nd = 0;
      repeat (300) begin
         @(posedge clk); #1;
         if (bus.done || !spi_cs_n) nd++;
      end
      checks++; if (nd !== 0) begin errs++; $display("FAIL rmid_no_done got=%0d want=0", nd); end
      do_frame(2'd0, 1'b0, 3'd4, 8'hC3, 8'h96, 0, 1'b0, 1'b0, td, tbz, dis, xd);
      checks++; if (td !== 272) begin errs++; $display("FAIL rmid_fresh_done got=%0d want=272", td); end
      checks++; if (mosi_cap !== 16'h84C3) begin errs++; $display("FAIL rmid_fresh_mosi got=%h want=84c3", mosi_cap); end
      checks++; if (bus.rdata !== 8'h96) begin errs++; $display("FAIL rmid_fresh_rdata got=%h want=96", bus.rdata); end
   endtask

   task automatic test_latency;
      int td, tbz, dis, xd;
      do_frame(2'd0, 1'b1, 3'd2, 8'h00, 8'hAA, 4, 1'b0, 1'b0, td, tbz, dis, xd);
      checks++; if (bus.rdata !== 8'hAA) begin errs++; $display("FAIL lat_rdata got=%h want=aa", bus.rdata); end
      checks++; if (mosi_cap !== 16'h0200) begin errs++; $display("FAIL lat_mosi got=%h want=0200", mosi_cap); end
      checks++; if (td !== 272) begin errs++; $display("FAIL lat_done_time got=%0d want=272", td); end
   endtask

   task automatic test_ena;
      int td, tbz, dis, xd;
      logic [7:0] w, rb;
      logic [2:0] a;
      w = 8'($urandom); rb = 8'($urandom); a = 3'($urandom);
      do_frame(2'd1, 1'b0, a, w, rb, 0, 1'b0, 1'b1, td, tbz, dis, xd);
      checks++; if (td !== 272 + dis) begin errs++; $display("FAIL ena_done_time got=%0d want=%0d", td, 272 + dis); end
      checks++; if (tbz !== td + 8) begin errs++; $display("FAIL ena_busy_fall got=%0d want=%0d", tbz, td + 8); end
      checks++; if (mosi_cap !== exp_frame(1'b0, a, w)) begin errs++; $display("FAIL ena_mosi got=%h want=%h", mosi_cap, exp_frame(1'b0, a, w)); end
      checks++; if (bus.rdata !== rb) begin errs++; $display("FAIL ena_rdata got=%h want=%h", bus.rdata, rb); end
      checks++; if (viol !== 0 || edges !== 32) begin errs++; $display("FAIL ena_sclk got=%0d/%0d want=0/32", viol, edges); end
   endtask

   task automatic test_random;
      int td, tbz, dis, xd;
      logic [1:0] m;
      logic r;
      logic [2:0] a;
      logic [7:0] w, rb;
      for (int n = 0; n < 10; n++) begin
         m = 2'($urandom); r = 1'($urandom); a = 3'($urandom); w = 8'($urandom); rb = 8'($urandom);
         do_frame(m, r, a, w, rb, $urandom_range(0, 4), 1'b0, 1'b0, td, tbz, dis, xd);
         checks++; if (mosi_cap !== exp_frame(r, a, w)) begin errs++; $display("FAIL rnd%0d_mosi got=%h want=%h", n, mosi_cap, exp_frame(r, a, w)); end
         checks++; if (bus.rdata !== rb) begin errs++; $display("FAIL rnd%0d_rdata got=%h want=%h", n, bus.rdata, rb); end
         checks++; if (td !== 272 || tbz !== 280) begin errs++; $display("FAIL rnd%0d_timing got=%0d/%0d want=272/280", n, td, tbz); end
         checks++; if (viol !== 0 || edges !== 32) begin errs++; $display("FAIL rnd%0d_sclk got=%0d/%0d want=0/32", n, viol, edges); end
      end
   endtask

   initial begin
      bus.mode = 2'd0; bus.req = 1'b0; bus.rnw = 1'b0; bus.addr = '0; bus.wdata = '0;
      test_reset();
      test_mode0_write();
      test_mode0_read();
      test_modes_write();
      test_ignore_req();
      test_reset_mid();
      test_latency();
      test_ena();
      test_random();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
